hw9: RTL and testbench

- Self-running 4-digit BCD seconds-style counter with a multiplexed 7-segment display driver.
- Top-level homework block: needs only a clock and reset; every output is observable but none is required to be connected.
- Internal prescaler generates a count tick; a scan divider rotates the active digit.

---
 rtl/hw9.sv | 122 ++++++++++++
 tb/tb_hw9.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hw9.sv
// Self-running 4-digit BCD counter with a multiplexed, active-low 7-segment scan driver.
// Reset asserts asynchronously and is released through a synchroniser before counting resumes.
module hw9 #(
  parameter int TICK_DIV = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [15:0] count_out,
  output logic        tick_out,
  output logic [3:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  logic          run_p0;
  logic [PW-1:0] presc;
  logic [SW-1:0] scan;
  logic [1:0]    idx;
  logic [3:0]    nibble;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] an_for(input logic [1:0] i);
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Release stage: the state registers below act as the second flop of the release path,
  // so the first increment lands on the second edge after rst_in falls.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) run_p0 <= 1'b0;
    else        run_p0 <= 1'b1;
  end

  // Prescaler and BCD count
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc     <= '0;
      tick_out  <= 1'b0;
      count_out <= 16'h0000;
    end else if (run_p0) begin
      if (presc == PMAX) begin
        presc     <= '0;
        tick_out  <= 1'b1;
        count_out <= bcd_inc(count_out);
      end else begin
        presc    <= presc + 1'b1;
        tick_out <= 1'b0;
      end
    end
  end

  // Digit scan; an_out moves with idx so the decoded nibble always matches the lit digit
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      scan   <= '0;
      idx    <= 2'd0;
      an_out <= 4'b1110;
    end else if (run_p0) begin
      if (scan == SMAX) begin
        scan   <= '0;
        idx    <= idx + 2'd1;
        an_out <= an_for(idx + 2'd1);
      end else begin
        scan <= scan + 1'b1;
      end
    end
  end

  always_comb begin
    nibble = count_out[3:0];
    case (idx)
      2'd0:    nibble = count_out[3:0];
      2'd1:    nibble = count_out[7:4];
      2'd2:    nibble = count_out[11:8];
      default: nibble = count_out[15:12];
    endcase
  end

  assign seg_out = seg_dec(nibble);
  assign dp_out  = 1'b1;

endmodule

// File: tb/tb_hw9.sv
// Scoreboard bench for hw9: a cycle-indexed arithmetic model predicts every output,
// a negedge monitor compares; random async resets are sprinkled in.
module tb_hw9;

  localparam int TD = 3;
  localparam int SD = 4;

  logic        clk;
  logic        rst_in;
  logic [15:0] count_out;
  logic        tick_out;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;

  hw9 #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .count_out(count_out),
    .tick_out(tick_out),
    .an_out(an_out),
    .seg_out(seg_out),
    .dp_out(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] count;
    logic        tick;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;
  int   e        = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // n = number of enabled edges since the counter was released
  function automatic exp_t model(input int n);
    exp_t r;
    int   v, ix;
    int   d [4];
    v  = (n / TD) % 10000;
    for (int k = 0; k < 4; k++) begin
      d[k] = v % 10;
      v    = v / 10;
    end
    ix      = (n / SD) % 4;
    r.count = {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
    r.tick  = (n > 0) && (n % TD == 0);
    r.an    = ~(4'b0001 << ix);
    r.seg   = seg_tab[ix == 0 ? d[0] : ix == 1 ? d[1] : ix == 2 ? d[2] : d[3]];
    return r;
  endfunction

  function automatic int cur_n();
    return (rst_in || e < 1) ? 0 : e - 1;
  endfunction

  // action: 0 run, 1 assert reset mid-phase, 2 release reset mid-phase
  task automatic cycle(input int action);
    @(posedge clk);
    if (rst_in) e = 0;
    else        e++;
    #2;
    if (action == 1) begin
      rst_in = 1'b1;
      e      = 0;
    end else if (action == 2) begin
      rst_in = 1'b0;
    end
    q.push_back(model(cur_n()));
    armed = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (armed) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 32'd0, 32'd1);
      end else begin
        x = q.pop_front();
        chk("count", {16'd0, count_out}, {16'd0, x.count});
        chk("tick",  {31'd0, tick_out},  {31'd0, x.tick});
        chk("an",    {28'd0, an_out},    {28'd0, x.an});
        chk("seg",   {25'd0, seg_out},   {25'd0, x.seg});
        chk("dp",    {31'd0, dp_out},    32'd1);
      end
    end
  end

  initial begin
    int guard;
    rst_in = 1'b1;
    repeat (3) cycle(0);
    cycle(2);
    repeat (40) cycle(0);

    for (int k = 0; k < 6; k++) begin
      cycle(1);
      repeat ($urandom_range(0, 3)) cycle(0);
      cycle(2);
      repeat ($urandom_range(5, 80)) cycle(0);
    end

    guard = 0;
    while ((cur_n() / SD) % 4 != 2 && guard < 40) begin
      cycle(0);
      guard++;
    end
    chk("reach_digit2", guard < 40 ? 32'd1 : 32'd0, 32'd1);
    cycle(1);
    cycle(0);
    cycle(2);
    repeat (20) cycle(0);

    cycle(1);
    cycle(2);
    repeat (10000 * TD + 60) cycle(0);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
